// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin encoding, feeder state encoding and prices shared with the vending controller
package vend_pkg;

   typedef enum logic {
      COIN_5  = 1'b0,
      COIN_10 = 1'b1
   } coin_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      SPACE = 2'd2
   } feeder_state_t;

   localparam int COIN_5_VALUE  = 5;
   localparam int COIN_10_VALUE = 10;
   localparam int BOTTLE_PRICE  = 15;

   function automatic int coin_value(input logic is_ten);
      return is_ten ? COIN_10_VALUE : COIN_5_VALUE;
   endfunction

endpackage

// File: rtl/coin_fifo.sv
// rtl/coin_fifo.sv - 1-bit coin type FIFO, head read combinationally from the read pointer
module coin_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     din,
   output logic                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - buffers acceptor coins and replays them as spaced one-cycle pulses, tallies dispenses
module coin_feeder
   import vend_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             coin_valid,
   input  logic             coin_is_ten,
   output logic             coin_ready,
   input  logic             pause,
   output logic             five_coin,
   output logic             ten_coin,
   input  logic             bottle,
   input  logic             change,
   output logic [CNT_W-1:0] bottles_out,
   output logic [CNT_W-1:0] changes_out,
   output logic             drop_err,
   output logic             busy
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   feeder_state_t        state;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 push;
   logic                 pop;

   assign coin_ready = !fifo_full;
   assign push       = coin_valid && coin_ready;
   assign pop        = (state == IDLE) && !fifo_empty && !pause;
   assign busy       = (fifo_count != '0) || (state != IDLE);

   coin_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (coin_is_ten),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         five_coin <= 1'b0;
         ten_coin  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state     <= ISSUE;
                  ten_coin  <= (fifo_head == COIN_10);
                  five_coin <= (fifo_head == COIN_5);
               end
            end
            ISSUE: begin
               five_coin <= 1'b0;
               ten_coin  <= 1'b0;
               gap_cnt   <= GAP_W'(GAP - 1);
               state     <= SPACE;
            end
            SPACE: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               five_coin <= 1'b0;
               ten_coin  <= 1'b0;
            end
         endcase
      end
   end

   // Tallies hold at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bottles_out <= '0;
         changes_out <= '0;
         drop_err    <= 1'b0;
      end else begin
         if (bottle && (bottles_out != '1)) begin
            bottles_out <= bottles_out + 1'b1;
         end
         if (change && (changes_out != '1)) begin
            changes_out <= changes_out + 1'b1;
         end
         if (coin_valid && !coin_ready) begin
            drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_coin_feeder.sv
// tb/tb_coin_feeder.sv - directed bench for coin_feeder with a small vending controller model
module tb_coin_feeder;
   import vend_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic       coin_is_ten;
   logic       coin_ready;
   logic       pause;
   logic       five_coin;
   logic       ten_coin;
   logic       bottle;
   logic       change;
   logic [7:0] bottles_out;
   logic [7:0] changes_out;
   logic       drop_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic model_bottle;
   logic model_change;
   logic force_bottle;
   int   credit;
   int   credit_nxt;

   always #5 clk = ~clk;

   coin_feeder #(.DEPTH(4), .GAP(1), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .coin_valid  (coin_valid),
      .coin_is_ten (coin_is_ten),
      .coin_ready  (coin_ready),
      .pause       (pause),
      .five_coin   (five_coin),
      .ten_coin    (ten_coin),
      .bottle      (bottle),
      .change      (change),
      .bottles_out (bottles_out),
      .changes_out (changes_out),
      .drop_err    (drop_err),
      .busy        (busy)
   );

   // Controller: dispenses once credit reaches the bottle price, returns change on overpay.
   always_comb begin
      credit_nxt = credit;
      if (five_coin) credit_nxt = credit_nxt + coin_value(1'b0);
      if (ten_coin)  credit_nxt = credit_nxt + coin_value(1'b1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         credit       <= 0;
         model_bottle <= 1'b0;
         model_change <= 1'b0;
      end else if (credit_nxt >= BOTTLE_PRICE) begin
         credit       <= 0;
         model_bottle <= 1'b1;
         model_change <= (credit_nxt > BOTTLE_PRICE);
      end else begin
         credit       <= credit_nxt;
         model_bottle <= 1'b0;
         model_change <= 1'b0;
      end
   end

   assign bottle = model_bottle | force_bottle;
   assign change = model_change;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   logic [31:0] five_mask;
   logic [31:0] ten_mask;
   int          pulses;

   initial begin
      reset        = 1'b0;
      coin_valid   = 1'b0;
      coin_is_ten  = 1'b0;
      pause        = 1'b0;
      force_bottle = 1'b0;
      step();
      do_reset();
      chk("rst_five", 32'(five_coin), 32'd0);
      chk("rst_ten", 32'(ten_coin), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(coin_ready), 32'd1);
      chk("rst_bottles", 32'(bottles_out), 32'd0);
      chk("rst_drop", 32'(drop_err), 32'd0);

      // 1: single ten coin, pulse at t0+2, idle again at t0+4
      coin_valid = 1'b1; coin_is_ten = 1'b1;
      step();
      coin_valid = 1'b0;
      chk("t1_c1_ten", 32'(ten_coin), 32'd0);
      chk("t1_c1_busy", 32'(busy), 32'd1);
      step();
      chk("t1_c2_ten", 32'(ten_coin), 32'd1);
      chk("t1_c2_five", 32'(five_coin), 32'd0);
      step();
      chk("t1_c3_ten", 32'(ten_coin), 32'd0);
      chk("t1_c3_busy", 32'(busy), 32'd1);
      step();
      chk("t1_c4_busy", 32'(busy), 32'd0);

      // 2: three fives back-to-back -> pulses at offsets 2,5,8
      do_reset();
      five_mask = '0; ten_mask = '0;
      for (int k = 0; k < 14; k++) begin
         coin_valid  = (k < 3);
         coin_is_ten = 1'b0;
         five_mask[k] = five_coin;
         ten_mask[k]  = ten_coin;
         step();
      end
      coin_valid = 1'b0;
      chk("t2_five_mask", five_mask, 32'h124);
      chk("t2_ten_mask", ten_mask, 32'h0);
      chk("t2_bottles", 32'(bottles_out), 32'd1);
      chk("t2_changes", 32'(changes_out), 32'd0);

      // 3: two tens -> pulses at offsets 2,5; bottle plus change
      do_reset();
      five_mask = '0; ten_mask = '0;
      for (int k = 0; k < 12; k++) begin
         coin_valid  = (k < 2);
         coin_is_ten = 1'b1;
         five_mask[k] = five_coin;
         ten_mask[k]  = ten_coin;
         step();
      end
      coin_valid = 1'b0;
      chk("t3_ten_mask", ten_mask, 32'h24);
      chk("t3_five_mask", five_mask, 32'h0);
      chk("t3_bottles", 32'(bottles_out), 32'd1);
      chk("t3_changes", 32'(changes_out), 32'd1);

      // 4: paused fill of a 4-deep FIFO, fifth coin dropped
      do_reset();
      pause = 1'b1;
      coin_is_ten = 1'b0;
      for (int k = 0; k < 5; k++) begin
         coin_valid = 1'b1;
         if (k == 4) chk("t4_ready_full", 32'(coin_ready), 32'd0);
         if (k == 3) chk("t4_ready_last", 32'(coin_ready), 32'd1);
         step();
      end
      coin_valid = 1'b0;
      chk("t4_drop_set", 32'(drop_err), 32'd1);
      chk("t4_no_pulse_paused", 32'(five_coin), 32'd0);
      pause = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (five_coin || ten_coin) pulses++;
      end
      chk("t4_pulses", 32'(pulses), 32'd4);
      chk("t4_drop_hold", 32'(drop_err), 32'd1);
      chk("t4_bottles", 32'(bottles_out), 32'd1);
      chk("t4_idle", 32'(busy), 32'd0);

      // 5: reset while in SPACE with two coins queued
      coin_is_ten = 1'b0;
      for (int k = 0; k < 3; k++) begin
         coin_valid = 1'b1;
         step();
      end
      coin_valid = 1'b0;
      chk("t5_space_busy", 32'(busy), 32'd1);
      chk("t5_space_five", 32'(five_coin), 32'd0);
      reset = 1'b0;
      step();
      chk("t5_five", 32'(five_coin), 32'd0);
      chk("t5_ten", 32'(ten_coin), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_bottles", 32'(bottles_out), 32'd0);
      chk("t5_changes", 32'(changes_out), 32'd0);
      chk("t5_drop", 32'(drop_err), 32'd0);
      reset = 1'b1;
      step();
      chk("t5_after_busy", 32'(busy), 32'd0);

      // 6: bottle held high -> tally saturates at 255
      force_bottle = 1'b1;
      for (int k = 0; k < 100; k++) step();
      chk("t6_bottles_100", 32'(bottles_out), 32'd100);
      for (int k = 0; k < 200; k++) step();
      chk("t6_bottles_sat", 32'(bottles_out), 32'd255);
      force_bottle = 1'b0;
      step();
      chk("t6_bottles_hold", 32'(bottles_out), 32'd255);
      chk("t6_changes", 32'(changes_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
